hazard_sequencer: RTL and testbench

Pipeline control sequencer for the 5-stage MIPS core (LW, SW, R-type, BEQ, J, ADDI). It consumes the `IDstall`/`EXstall` outputs of `StallDetection`, plus branch resolution and data-memory wait. It drives every pipeline-register write enable, bubble/flush control and PC update. It also runs a post-reset pipeline-flush sequence, a stall watchdog and saturating hazard counters.

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/hazard_sequencer_if.sv | 42 ++++
 rtl/sat_counter.sv | 26 ++
 rtl/hazard_sequencer.sv | 150 +++++++++++++++
 tb/tb_hazard_sequencer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control: sequencer states
// and the opcode set handled by the core.
package pipeline_pkg;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        STALL  = 2'd2,
        FREEZE = 2'd3
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// Hazard inputs and pipeline control outputs of the sequencer. The master side
// is the hazard source (StallDetection / branch unit); the slave is the sequencer.
interface hazard_sequencer_if
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             id_stall;
    logic             ex_stall;
    logic             id_branch_taken;
    logic             id_jump;
    logic             mem_wait;

    logic             pc_we;
    logic             pc_sel_target;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_we;
    logic             idex_bubble;
    logic             exmem_we;
    logic             exmem_bubble;
    logic             memwb_we;
    logic             stall_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    state_t           state;

    modport master (
        output id_stall, ex_stall, id_branch_taken, id_jump, mem_wait,
        input  pc_we, pc_sel_target, ifid_we, ifid_flush, idex_we, idex_bubble,
               exmem_we, exmem_bubble, memwb_we, stall_timeout,
               stall_count, flush_count, state
    );

    modport slave (
        input  id_stall, ex_stall, id_branch_taken, id_jump, mem_wait,
        output pc_we, pc_sel_target, ifid_we, ifid_flush, idex_we, idex_bubble,
               exmem_we, exmem_bubble, memwb_we, stall_timeout,
               stall_count, flush_count, state
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr has priority over inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign q = count_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline control sequencer: post-reset flush, zero-latency hazard decode into
// register enables/bubbles, stall watchdog and saturating hazard counters.
module hazard_sequencer
    import pipeline_pkg::*;
#(
    parameter int INIT_CYCLES = 4,
    parameter int MAX_STALL   = 8,
    parameter int CNT_W       = 16
) (
    input logic               clk,
    input logic               rst_n,
    hazard_sequencer_if.slave bus
);

    localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);
    localparam logic [7:0] STALL_MAX = 8'(MAX_STALL);

    state_t     state_q;
    logic [3:0] init_cnt_q;
    logic [7:0] consec_q;
    logic       timeout_q;

    state_t     class_d;
    logic       flush_d;
    logic       pc_we_d;
    logic       pc_sel_d;
    logic       ifid_we_d;
    logic       ifid_flush_d;
    logic       idex_we_d;
    logic       idex_bubble_d;
    logic       exmem_we_d;
    logic       exmem_bubble_d;
    logic       memwb_we_d;

    // Controls must act in the same cycle the hazard is seen, so they are
    // decoded straight from the inputs; only INIT depends on registered state.
    always_comb begin
        class_d        = RUN;
        flush_d        = 1'b0;
        pc_we_d        = 1'b0;
        pc_sel_d       = 1'b0;
        ifid_we_d      = 1'b0;
        ifid_flush_d   = 1'b0;
        idex_we_d      = 1'b0;
        idex_bubble_d  = 1'b0;
        exmem_we_d     = 1'b0;
        exmem_bubble_d = 1'b0;
        memwb_we_d     = 1'b0;

        if (state_q == INIT) begin
            class_d        = INIT;
            ifid_we_d      = 1'b1;
            ifid_flush_d   = 1'b1;
            idex_we_d      = 1'b1;
            idex_bubble_d  = 1'b1;
            exmem_we_d     = 1'b1;
            exmem_bubble_d = 1'b1;
        end else if (bus.mem_wait) begin
            class_d = FREEZE;
        end else if (bus.ex_stall) begin
            class_d        = STALL;
            exmem_we_d     = 1'b1;
            exmem_bubble_d = 1'b1;
            memwb_we_d     = 1'b1;
        end else if (bus.id_stall) begin
            class_d       = STALL;
            idex_we_d     = 1'b1;
            idex_bubble_d = 1'b1;
            exmem_we_d    = 1'b1;
            memwb_we_d    = 1'b1;
        end else begin
            // A redirect seen during a stall is dropped here and picked up
            // again once ID is allowed to advance.
            flush_d      = bus.id_branch_taken | bus.id_jump;
            pc_we_d      = 1'b1;
            pc_sel_d     = flush_d;
            ifid_flush_d = flush_d;
            ifid_we_d    = 1'b1;
            idex_we_d    = 1'b1;
            exmem_we_d   = 1'b1;
            memwb_we_d   = 1'b1;
        end
    end

    // Sequencer state, init flush timer and the consecutive-stall watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            consec_q   <= '0;
            timeout_q  <= 1'b0;
        end else if (state_q == INIT) begin
            if (init_cnt_q == INIT_LAST) begin
                state_q    <= RUN;
                init_cnt_q <= '0;
            end else begin
                init_cnt_q <= init_cnt_q + 4'd1;
            end
        end else begin
            state_q <= class_d;
            case (class_d)
                STALL: begin
                    if (consec_q != 8'hFF) begin
                        consec_q <= consec_q + 8'd1;
                    end
                    if ((consec_q + 8'd1) == STALL_MAX) begin
                        timeout_q <= 1'b1;
                    end
                end
                RUN:     consec_q <= '0;
                default: consec_q <= consec_q;
            endcase
        end
    end

    logic stall_inc;
    logic flush_inc;

    assign stall_inc = (class_d == STALL);
    assign flush_inc = (class_d == RUN) && flush_d;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .clr   (1'b0),
        .q     (bus.stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .clr   (1'b0),
        .q     (bus.flush_count)
    );

    assign bus.pc_we         = pc_we_d;
    assign bus.pc_sel_target = pc_sel_d;
    assign bus.ifid_we       = ifid_we_d;
    assign bus.ifid_flush    = ifid_flush_d;
    assign bus.idex_we       = idex_we_d;
    assign bus.idex_bubble   = idex_bubble_d;
    assign bus.exmem_we      = exmem_we_d;
    assign bus.exmem_bubble  = exmem_bubble_d;
    assign bus.memwb_we      = memwb_we_d;
    assign bus.stall_timeout = timeout_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed hazard scenarios followed by random
// hazard traffic, all compared against a cycle-level behavioural model.
module tb_hazard_sequencer;
    import pipeline_pkg::*;

    localparam int INIT_CYCLES = 4;
    localparam int MAX_STALL   = 8;
    localparam int CNT_W       = 3;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    // Expected control vectors, ordered {pc_we, pc_sel_target, ifid_we,
    // ifid_flush, idex_we, idex_bubble, exmem_we, exmem_bubble, memwb_we}.
    localparam logic [8:0] V_INIT   = 9'b001111110;
    localparam logic [8:0] V_FREEZE = 9'b000000000;
    localparam logic [8:0] V_EXSTL  = 9'b000000111;
    localparam logic [8:0] V_IDSTL  = 9'b000011101;
    localparam logic [8:0] V_FLUSH  = 9'b111110101;
    localparam logic [8:0] V_RUN    = 9'b101010101;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    hazard_sequencer_if #(.CNT_W(CNT_W)) bus ();

    hazard_sequencer #(
        .INIT_CYCLES (INIT_CYCLES),
        .MAX_STALL   (MAX_STALL),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;

    int   initLeft;
    int   consec;
    int   stallCnt;
    int   flushCnt;
    int   expState;
    logic expTimeout;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic logic [8:0] ctrlVec();
        return {bus.pc_we, bus.pc_sel_target, bus.ifid_we, bus.ifid_flush,
                bus.idex_we, bus.idex_bubble, bus.exmem_we, bus.exmem_bubble,
                bus.memwb_we};
    endfunction

    task automatic checkAll(input string tag, input logic [8:0] expCtrl);
        checkOutput({tag, "/ctrl"},    32'(ctrlVec()),          32'(expCtrl));
        checkOutput({tag, "/state"},   32'(bus.state),          32'(expState));
        checkOutput({tag, "/stalls"},  32'(bus.stall_count),    32'(stallCnt));
        checkOutput({tag, "/flushes"}, 32'(bus.flush_count),    32'(flushCnt));
        checkOutput({tag, "/timeout"}, 32'(bus.stall_timeout),  32'(expTimeout));
    endtask

    // One pipeline cycle: drive hazards after the falling edge, check the
    // zero-latency controls, then advance the model across the rising edge.
    task automatic applyStimulus(input string tag, input logic ms, input logic ex,
                                 input logic id, input logic br, input logic jp);
        logic [8:0] expCtrl;
        int         cls;
        logic       redirect;
        @(negedge clk);
        bus.mem_wait        = ms;
        bus.ex_stall        = ex;
        bus.id_stall        = id;
        bus.id_branch_taken = br;
        bus.id_jump         = jp;
        #1;
        redirect = 1'b0;
        if (initLeft > 0) begin
            cls = 0; expCtrl = V_INIT;
        end else if (ms) begin
            cls = 3; expCtrl = V_FREEZE;
        end else if (ex) begin
            cls = 2; expCtrl = V_EXSTL;
        end else if (id) begin
            cls = 2; expCtrl = V_IDSTL;
        end else if (br || jp) begin
            cls = 1; expCtrl = V_FLUSH; redirect = 1'b1;
        end else begin
            cls = 1; expCtrl = V_RUN;
        end
        checkAll(tag, expCtrl);
        @(posedge clk);
        if (initLeft > 0) begin
            initLeft--;
            expState = (initLeft == 0) ? 1 : 0;
        end else begin
            expState = cls;
            if (cls == 2) begin
                if (stallCnt < CNT_MAX) stallCnt++;
                if (consec < 255) consec++;
                if (consec == MAX_STALL) expTimeout = 1'b1;
            end else if (cls == 1) begin
                consec = 0;
                if (redirect && flushCnt < CNT_MAX) flushCnt++;
            end
        end
    endtask

    // Asynchronous reset in the middle of a cycle, with hazards set to show
    // they are ignored; released mid-cycle after one rising edge.
    task automatic pulseReset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        bus.mem_wait        = 1'($urandom_range(0, 1));
        bus.ex_stall        = 1'($urandom_range(0, 1));
        bus.id_stall        = 1'($urandom_range(0, 1));
        bus.id_branch_taken = 1'($urandom_range(0, 1));
        bus.id_jump         = 1'($urandom_range(0, 1));
        initLeft   = INIT_CYCLES;
        consec     = 0;
        stallCnt   = 0;
        flushCnt   = 0;
        expState   = 0;
        expTimeout = 1'b0;
        #1;
        checkAll(tag, V_INIT);
        @(posedge clk);
        #2;
        checkAll({tag, "_held"}, V_INIT);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.mem_wait        = 1'b0;
        bus.ex_stall        = 1'b0;
        bus.id_stall        = 1'b0;
        bus.id_branch_taken = 1'b0;
        bus.id_jump         = 1'b0;

        pulseReset("rst");
        for (int i = 0; i < INIT_CYCLES; i++) applyStimulus("init", 0, 1, 1, 1, 1);
        applyStimulus("first_run", 0, 0, 0, 0, 0);

        applyStimulus("ex_id", 0, 1, 1, 0, 0);
        applyStimulus("after_ex_id", 0, 0, 0, 0, 0);

        applyStimulus("stall_br0", 0, 0, 1, 1, 0);
        applyStimulus("stall_br1", 0, 0, 1, 1, 0);
        applyStimulus("br_redo", 0, 0, 0, 1, 0);
        applyStimulus("after_br", 0, 0, 0, 0, 0);

        applyStimulus("freeze_ex", 1, 1, 0, 0, 0);
        applyStimulus("after_frz", 0, 0, 0, 0, 0);

        for (int i = 0; i < 4; i++) applyStimulus("wd_a", 0, 0, 1, 0, 0);
        applyStimulus("wd_freeze", 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus("wd_b", 0, 0, 1, 0, 0);
        applyStimulus("wd_clear", 0, 0, 0, 0, 0);
        applyStimulus("wd_sticky", 0, 0, 0, 0, 0);

        pulseReset("rst_sat");
        for (int i = 0; i < INIT_CYCLES; i++) applyStimulus("init2", 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) applyStimulus("jumps", 0, 0, 0, i[0], 1);
        applyStimulus("sat_hold", 0, 0, 0, 0, 0);
        pulseReset("rst_mid");
        for (int i = 0; i < INIT_CYCLES; i++) applyStimulus("init3", 0, 0, 0, 0, 0);

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 79) == 0) begin
                pulseReset("rnd_rst");
            end else begin
                applyStimulus("rnd",
                              $urandom_range(0, 9) == 0,
                              $urandom_range(0, 5) == 0,
                              $urandom_range(0, 2) == 0,
                              $urandom_range(0, 3) == 0,
                              $urandom_range(0, 5) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
